bus_msg_serializer: RTL and testbench

- Host-side transmitter that drives the 32-bit write-beat bus consumed by the bus-to-message adapter.
- Queues whole portal messages and emits each as a burst of beats with a final-beat flag.
- Beat order is most-significant word first, so the receiver's shift-left accumulation rebuilds the message with word 0 (the header carrying the interface id) in bits [31:0].
- Used in simulation tops and loopback benches as the stimulus end of the request path.

---
 rtl/bus_msg_serializer.sv | 205 ++++++++++++++++++++
 tb/tb_bus_msg_serializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_msg_serializer.sv
// bus_msg_serializer: queues whole portal messages and emits each one as a
// burst of BEAT_WIDTH beats, most-significant word first, with a final-beat
// flag. Word 0 (the header) is always the last beat of its message.
module bus_msg_serializer #(
    parameter int DATA_WIDTH = 128,
    parameter int BEAT_WIDTH = 32,
    parameter int QDEPTH     = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN_msg,
    output logic                  RDY_msg,
    input  logic [DATA_WIDTH-1:0] msgData,
    input  logic [7:0]            msgWords,
    output logic                  EN_writeBeat,
    input  logic                  RDY_writeBeat,
    output logic [BEAT_WIDTH-1:0] writeData,
    output logic                  writeLast,
    output logic                  errLength,
    output logic [15:0]           sentCount
);

    localparam int WORDS = DATA_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int OCC_W = $clog2(QDEPTH + 1);

    localparam logic [7:0]       WORDS_8  = 8'(WORDS);
    localparam logic [CNT_W-1:0] WORDS_C  = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(QDEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // message queue storage (circular buffer)
    logic [DATA_WIDTH-1:0] q_data_q  [QDEPTH];
    logic [CNT_W-1:0]      q_words_q [QDEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // loaded message and beat engine
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] msg_q, msg_d;
    logic [CNT_W-1:0]      beats_left_q, beats_left_d;
    logic                  err_q, err_d;
    logic [15:0]           sent_q, sent_d;

    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [CNT_W-1:0]      words_norm_s;
    logic                  len_err_s;
    logic                  en_s;
    logic                  last_s;
    logic [BEAT_WIDTH-1:0] data_s;
    logic [CNT_W-1:0]      beat_idx_s;
    logic [WORDS-1:0][BEAT_WIDTH-1:0] msg_words_s;

    assign full_s      = (occ_q == FULL_OCC);
    assign empty_s     = (occ_q == {OCC_W{1'b0}});
    assign push_s      = EN_msg && !full_s;
    assign msg_words_s = msg_q;
    assign beat_idx_s  = beats_left_q - ONE_C;

    // clamp the requested beat count into 1..WORDS and flag illegal requests
    always_comb begin
        words_norm_s = ONE_C;
        len_err_s    = 1'b0;
        if (msgWords == 8'd0) begin
            words_norm_s = ONE_C;
            len_err_s    = 1'b1;
        end else if (msgWords > WORDS_8) begin
            words_norm_s = WORDS_C;
            len_err_s    = 1'b1;
        end else begin
            words_norm_s = msgWords[CNT_W-1:0];
            len_err_s    = 1'b0;
        end
    end

    // beat outputs: only valid in SEND and forced quiet while reset is held
    always_comb begin
        en_s   = 1'b0;
        last_s = 1'b0;
        data_s = {BEAT_WIDTH{1'b0}};
        if (RST_N && (state_q == ST_SEND)) begin
            en_s   = RDY_writeBeat;
            last_s = (beats_left_q == ONE_C);
            data_s = msg_words_s[beat_idx_s[IDX_W-1:0]];
        end else begin
            en_s   = 1'b0;
            last_s = 1'b0;
            data_s = {BEAT_WIDTH{1'b0}};
        end
    end

    // FSM next state: load from queue head in IDLE or straight after a last beat
    always_comb begin
        state_d      = state_q;
        msg_d        = msg_q;
        beats_left_d = beats_left_q;
        sent_d       = sent_q;
        pop_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    msg_d        = q_data_q[rd_ptr_q];
                    beats_left_d = q_words_q[rd_ptr_q];
                    state_d      = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (en_s && last_s) begin
                    sent_d = sent_q + 16'd1;
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        msg_d        = q_data_q[rd_ptr_q];
                        beats_left_d = q_words_q[rd_ptr_q];
                        state_d      = ST_SEND;
                    end else begin
                        beats_left_d = {CNT_W{1'b0}};
                        state_d      = ST_IDLE;
                    end
                end else if (en_s) begin
                    beats_left_d = beats_left_q - ONE_C;
                end else begin
                    beats_left_d = beats_left_q;
                end
            end
            default: begin
                beats_left_d = {CNT_W{1'b0}};
                state_d      = ST_IDLE;
            end
        endcase
    end

    // queue pointer and occupancy bookkeeping; pointers wrap modulo QDEPTH
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        err_d    = err_q | (push_s & len_err_s);
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            msg_q        <= {DATA_WIDTH{1'b0}};
            beats_left_q <= {CNT_W{1'b0}};
            sent_q       <= 16'd0;
            err_q        <= 1'b0;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            occ_q        <= {OCC_W{1'b0}};
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            beats_left_q <= beats_left_d;
            sent_q       <= sent_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
        end
    end

    // queue entry write on push; entries cleared on reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_data_q[i]  <= {DATA_WIDTH{1'b0}};
                q_words_q[i] <= {CNT_W{1'b0}};
            end
        end else if (push_s) begin
            q_data_q[wr_ptr_q]  <= msgData;
            q_words_q[wr_ptr_q] <= words_norm_s;
        end else begin
            q_data_q[wr_ptr_q]  <= q_data_q[wr_ptr_q];
            q_words_q[wr_ptr_q] <= q_words_q[wr_ptr_q];
        end
    end

    assign RDY_msg      = !RST_N || !full_s;
    assign EN_writeBeat = en_s;
    assign writeLast    = last_s;
    assign writeData    = data_s;
    assign errLength    = err_q;
    assign sentCount    = sent_q;

endmodule

// File: tb/tb_bus_msg_serializer.sv
// Directed testbench for bus_msg_serializer with hand-computed expectations.
module tb_bus_msg_serializer;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         EN_msg;
    logic         RDY_msg;
    logic [127:0] msgData;
    logic [7:0]   msgWords;
    logic         EN_writeBeat;
    logic         RDY_writeBeat;
    logic [31:0]  writeData;
    logic         writeLast;
    logic         errLength;
    logic [15:0]  sentCount;

    int vectors = 0;
    int miscompares = 0;

    bus_msg_serializer #(
        .DATA_WIDTH(128),
        .BEAT_WIDTH(32),
        .QDEPTH(2)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .EN_msg(EN_msg),
        .RDY_msg(RDY_msg),
        .msgData(msgData),
        .msgWords(msgWords),
        .EN_writeBeat(EN_writeBeat),
        .RDY_writeBeat(RDY_writeBeat),
        .writeData(writeData),
        .writeLast(writeLast),
        .errLength(errLength),
        .sentCount(sentCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input string tag, input logic [127:0] d, input logic [7:0] w);
        msgData  = d;
        msgWords = w;
        EN_msg   = 1'b1;
        #1 chk({tag, "_rdy_msg"}, 32'(RDY_msg), 32'd1);
        tick();
        EN_msg = 1'b0;
    endtask

    task automatic idle_cyc(input string tag);
        #1 chk({tag, "_en_idle"}, 32'(EN_writeBeat), 32'd0);
        tick();
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic last);
        #1;
        chk({tag, "_en"}, 32'(EN_writeBeat), 32'd1);
        chk({tag, "_data"}, writeData, d);
        chk({tag, "_last"}, 32'(writeLast), 32'(last));
        tick();
    endtask

    task automatic stall(input string tag, input logic [31:0] d, input logic last);
        RDY_writeBeat = 1'b0;
        #1;
        chk({tag, "_en_stall"}, 32'(EN_writeBeat), 32'd0);
        chk({tag, "_data_held"}, writeData, d);
        chk({tag, "_last_held"}, 32'(writeLast), 32'(last));
        tick();
    endtask

    initial begin
        RST_N         = 1'b0;
        EN_msg        = 1'b0;
        msgData       = 128'd0;
        msgWords      = 8'd0;
        RDY_writeBeat = 1'b0;

        // reset state
        #1;
        chk("rst_rdy_msg", 32'(RDY_msg), 32'd1);
        chk("rst_en", 32'(EN_writeBeat), 32'd0);
        chk("rst_data", writeData, 32'd0);
        chk("rst_last", 32'(writeLast), 32'd0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        chk("post_rst_err", 32'(errLength), 32'd0);
        chk("post_rst_sent", 32'(sentCount), 32'd0);
        chk("post_rst_rdy_msg", 32'(RDY_msg), 32'd1);

        // single 4-word message, MS word first
        RDY_writeBeat = 1'b1;
        push("single", 128'h44444444_33333333_22222222_00050001, 8'd4);
        idle_cyc("single_t1");
        beat("single_b0", 32'h44444444, 1'b0);
        beat("single_b1", 32'h33333333, 1'b0);
        beat("single_b2", 32'h22222222, 1'b0);
        beat("single_b3", 32'h00050001, 1'b1);
        idle_cyc("single_done");
        chk("single_sent", 32'(sentCount), 32'd1);
        chk("single_err", 32'(errLength), 32'd0);

        // back-to-back messages with no bubble
        push("b2b_a", 128'h0_0_AAAA0001_AAAA0000, 8'd2);
        push("b2b_b", 128'h0_0_0_BBBB0000, 8'd1);
        beat("b2b_a1", 32'hAAAA0001, 1'b0);
        beat("b2b_a0", 32'hAAAA0000, 1'b1);
        beat("b2b_b0", 32'hBBBB0000, 1'b1);
        idle_cyc("b2b_done");
        chk("b2b_sent", 32'(sentCount), 32'd3);

        // backpressure 1,0,0,1,1 over a 3-word message
        push("bp", 128'h0_CCCC0002_CCCC0001_CCCC0000, 8'd3);
        idle_cyc("bp_t1");
        beat("bp_b2", 32'hCCCC0002, 1'b0);
        stall("bp_s0", 32'hCCCC0001, 1'b0);
        stall("bp_s1", 32'hCCCC0001, 1'b0);
        RDY_writeBeat = 1'b1;
        beat("bp_b1", 32'hCCCC0001, 1'b0);
        beat("bp_b0", 32'hCCCC0000, 1'b1);
        idle_cyc("bp_done");
        chk("bp_sent", 32'(sentCount), 32'd4);

        // full queue: one loaded plus two queued, then drain in order
        RDY_writeBeat = 1'b0;
        push("full_d0", 128'h0_0_0_D0000000, 8'd1);
        push("full_d1", 128'h0_0_0_D0000001, 8'd1);
        push("full_d2", 128'h0_0_0_D0000002, 8'd1);
        #1;
        chk("full_rdy_msg_a", 32'(RDY_msg), 32'd0);
        chk("full_en_a", 32'(EN_writeBeat), 32'd0);
        chk("full_data_a", writeData, 32'hD0000000);
        tick();
        #1 chk("full_rdy_msg_b", 32'(RDY_msg), 32'd0);
        tick();
        RDY_writeBeat = 1'b1;
        #1;
        chk("full_rdy_msg_popcyc", 32'(RDY_msg), 32'd0);
        chk("full_d0_en", 32'(EN_writeBeat), 32'd1);
        chk("full_d0_data", writeData, 32'hD0000000);
        chk("full_d0_last", 32'(writeLast), 32'd1);
        tick();
        msgData  = 128'h0_0_0_D0000003;
        msgWords = 8'd1;
        EN_msg   = 1'b1;
        #1;
        chk("full_rdy_msg_back", 32'(RDY_msg), 32'd1);
        chk("full_d1_en", 32'(EN_writeBeat), 32'd1);
        chk("full_d1_data", writeData, 32'hD0000001);
        chk("full_d1_last", 32'(writeLast), 32'd1);
        tick();
        EN_msg = 1'b0;
        beat("full_d2", 32'hD0000002, 1'b1);
        beat("full_d3", 32'hD0000003, 1'b1);
        idle_cyc("full_done");
        chk("full_sent", 32'(sentCount), 32'd8);

        // illegal lengths: 0 -> 1 beat, 9 -> 4 beats, sticky error
        chk("ill_err_before", 32'(errLength), 32'd0);
        push("ill_zero", 128'hE3E30000_E2E20000_E1E10000_E0E00000, 8'd0);
        #1 chk("ill_err_set", 32'(errLength), 32'd1);
        idle_cyc("ill_zero_t1");
        beat("ill_zero_b0", 32'hE0E00000, 1'b1);
        push("ill_nine", 128'hF3F30000_F2F20000_F1F10000_F0F00000, 8'd9);
        idle_cyc("ill_nine_t1");
        beat("ill_nine_b3", 32'hF3F30000, 1'b0);
        beat("ill_nine_b2", 32'hF2F20000, 1'b0);
        beat("ill_nine_b1", 32'hF1F10000, 1'b0);
        beat("ill_nine_b0", 32'hF0F00000, 1'b1);
        idle_cyc("ill_done");
        chk("ill_err_sticky", 32'(errLength), 32'd1);
        chk("ill_sent", 32'(sentCount), 32'd10);

        // reset in the middle of a burst
        push("mid", 128'h66660003_66660002_66660001_66660000, 8'd4);
        idle_cyc("mid_t1");
        beat("mid_b3", 32'h66660003, 1'b0);
        beat("mid_b2", 32'h66660002, 1'b0);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_en", 32'(EN_writeBeat), 32'd0);
        chk("mid_rst_rdy_msg", 32'(RDY_msg), 32'd1);
        chk("mid_rst_data", writeData, 32'd0);
        chk("mid_rst_last", 32'(writeLast), 32'd0);
        tick();
        RST_N = 1'b1;
        #1;
        chk("mid_after_en", 32'(EN_writeBeat), 32'd0);
        chk("mid_after_rdy_msg", 32'(RDY_msg), 32'd1);
        chk("mid_after_sent", 32'(sentCount), 32'd0);
        chk("mid_after_err", 32'(errLength), 32'd0);
        tick();
        idle_cyc("mid_quiet");
        push("mid_new", 128'h0_0_77770001_77770000, 8'd2);
        idle_cyc("mid_new_t1");
        beat("mid_new_b1", 32'h77770001, 1'b0);
        beat("mid_new_b0", 32'h77770000, 1'b1);
        idle_cyc("mid_new_done");
        chk("mid_new_sent", 32'(sentCount), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
